// File: rtl/ffra_pkg.sv
// Shared definitions for the ffra multiply-add pipeline and its dot-product sequencer.
package ffra_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    // Latency of the ffra pipeline; also the number of interleaved partial-sum lanes.
    localparam int MAC_LAT = 4;

endpackage

// File: rtl/ffra.sv
// ffra multiply-add pipeline: o = a*b + ci, MAC_LAT cycles of latency, no reset.
module ffra
    import ffra_pkg::*;
#(
    parameter int BITS = 4
) (
    input  logic              clk,
    input  logic [BITS-1:0]   a,
    input  logic [BITS-1:0]   b,
    input  logic [2*BITS-1:0] ci,
    output logic [2*BITS-1:0] o
);

    logic [2*BITS-1:0] stage_q [0:MAC_LAT-1];

    always_ff @(posedge clk) begin
        stage_q[0] <= ({{BITS{1'b0}}, a} * {{BITS{1'b0}}, b}) + ci;
        for (int i = 1; i < MAC_LAT; i++) begin
            stage_q[i] <= stage_q[i-1];
        end
    end

    assign o = stage_q[MAC_LAT-1];

endmodule

// File: rtl/ffra_dot_seq.sv
// Dot-product sequencer: streams operand pairs into ffra, recirculates its output as
// MAC_LAT interleaved partial-sum lanes, then folds the lanes into one result.
module ffra_dot_seq
    import ffra_pkg::*;
#(
    parameter int BITS  = 4,
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    input  logic [BITS-1:0]   in_a,
    input  logic [BITS-1:0]   in_b,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [2*BITS-1:0] result,
    output logic [BITS-1:0]   mac_a,
    output logic [BITS-1:0]   mac_b,
    output logic [2*BITS-1:0] mac_ci,
    input  logic [2*BITS-1:0] mac_o
);

    localparam logic [2:0] CYC_MAX  = 3'(MAC_LAT);
    localparam logic [1:0] DCNT_MAX = 2'(MAC_LAT - 1);

    seq_state_e        state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [2:0]        cyc_q, cyc_d;
    logic [1:0]        dcnt_q, dcnt_d;
    logic [2*BITS-1:0] acc_q, acc_d;
    logic [2*BITS-1:0] result_q, result_d;
    logic              fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            cyc_q    <= '0;
            dcnt_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            cyc_q    <= cyc_d;
            dcnt_q   <= dcnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        cyc_d    = cyc_q;
        dcnt_d   = dcnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        in_ready = 1'b0;
        fire     = 1'b0;
        mac_a    = '0;
        mac_b    = '0;
        mac_ci   = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d    = len;
                    acc_d    = '0;
                    cyc_d    = '0;
                    dcnt_d   = '0;
                    result_d = '0;
                    state_d  = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                in_ready = (rem_q != '0);
                fire     = in_valid && in_ready;
                if (fire) begin
                    mac_a = in_a;
                    mac_b = in_b;
                end
                rem_d = rem_q - LEN_W'(fire);
                // Until every lane has issued once, ffra holds nothing of this job.
                if (cyc_q >= CYC_MAX) begin
                    mac_ci = mac_o;
                end else begin
                    cyc_d = cyc_q + 3'd1;
                end
                if ((rem_d == '0) && (cyc_q >= CYC_MAX - 3'd1)) begin
                    dcnt_d  = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                acc_d  = acc_q + mac_o;
                dcnt_d = dcnt_q + 2'd1;
                if (dcnt_q == DCNT_MAX) begin
                    result_d = acc_d;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_ffra_dot_seq.sv
// Bench for ffra_dot_seq driving a real ffra pipeline; table jobs, reset corner and random jobs.
module tb_ffra_dot_seq;

    localparam int BITS  = 4;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             in_valid = 1'b0;
    logic [BITS-1:0]  in_a = '0;
    logic [BITS-1:0]  in_b = '0;
    logic             in_ready, busy, done;
    logic [7:0]       result;
    logic [BITS-1:0]  mac_a, mac_b;
    logic [7:0]       mac_ci, mac_o;

    ffra_dot_seq #(.BITS(BITS), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
        .busy(busy), .done(done), .result(result),
        .mac_a(mac_a), .mac_b(mac_b), .mac_ci(mac_ci), .mac_o(mac_o)
    );

    ffra #(.BITS(BITS)) u_mac (
        .clk(clk), .a(mac_a), .b(mac_b), .ci(mac_ci), .o(mac_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [3:0] ja [0:63];
    logic [3:0] jb [0:63];

    typedef struct {
        int         n;
        int         mode;
        bit         hold;
        int         exp;
        logic [3:0] a [0:7];
        logic [3:0] b [0:7];
    } vec_t;

    vec_t vecs [0:5];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // mode 0: back-to-back, 1: valid toggles, 2: random valid
    task automatic run_job(input string nm, input int n, input int mode, input bit hold, input int exp);
        int  idx, s_cyc, d_cyc, last_acc, exp_done;
        bit  got, rdy_bad, v;
        @(negedge clk);
        start = 1'b1; len = 8'(n); in_valid = 1'b0;
        s_cyc = cyc; idx = 0; got = 0; rdy_bad = 0; last_acc = s_cyc; d_cyc = 0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (done) begin
                got = 1; d_cyc = cyc; in_valid = 1'b0;
            end else begin
                if (in_ready && idx >= n) rdy_bad = 1;
                case (mode)
                    0:       v = (idx < n);
                    1:       v = (k % 2 == 0) && (idx < n);
                    default: v = (idx < n) && ($urandom_range(0, 2) != 0);
                endcase
                in_valid = v;
                in_a = v ? ja[idx] : 4'd0;
                in_b = v ? jb[idx] : 4'd0;
                if (v && in_ready) begin
                    idx++; last_acc = cyc;
                end
            end
        end
        chk({nm, " completes"}, int'(got), 1);
        if (got) begin
            exp_done = (n == 0) ? s_cyc + 1 : ((last_acc > s_cyc + 4) ? last_acc : s_cyc + 4) + 5;
            chk({nm, " result"}, int'(result), exp);
            chk({nm, " done cycle"}, d_cyc - s_cyc, exp_done - s_cyc);
            chk({nm, " accepted"}, idx, n);
            chk({nm, " ready at rem0"}, int'(rdy_bad), 0);
            @(negedge clk);
            start = 1'b0;
            chk({nm, " done pulse width"}, int'(done), 0);
            chk({nm, " idle after done"}, int'(busy), 0);
            chk({nm, " result held"}, int'(result), exp);
        end
    endtask

    task automatic load_vec(input int i);
        for (int j = 0; j < 8; j++) begin
            ja[j] = vecs[i].a[j];
            jb[j] = vecs[i].b[j];
        end
    endtask

    initial begin
        vecs[0] = '{n:3, mode:0, hold:0, exp:32,  a:'{1,2,3,0,0,0,0,0}, b:'{4,5,6,0,0,0,0,0}};
        vecs[1] = '{n:6, mode:1, hold:0, exp:91,  a:'{1,2,3,4,5,6,0,0}, b:'{1,2,3,4,5,6,0,0}};
        vecs[2] = '{n:4, mode:0, hold:0, exp:132, a:'{15,15,15,15,0,0,0,0}, b:'{15,15,15,15,0,0,0,0}};
        vecs[3] = '{n:0, mode:0, hold:0, exp:0,   a:'{0,0,0,0,0,0,0,0}, b:'{0,0,0,0,0,0,0,0}};
        vecs[4] = '{n:3, mode:0, hold:1, exp:32,  a:'{1,2,3,0,0,0,0,0}, b:'{4,5,6,0,0,0,0,0}};
        vecs[5] = '{n:1, mode:0, hold:0, exp:63,  a:'{7,0,0,0,0,0,0,0}, b:'{9,0,0,0,0,0,0,0}};

        repeat (3) @(negedge clk);
        chk("reset in_ready", int'(in_ready), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset result", int'(result), 0);
        chk("reset mac_ci", int'(mac_ci), 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            load_vec(i);
            run_job($sformatf("vec%0d", i), vecs[i].n, vecs[i].mode, vecs[i].hold, vecs[i].exp);
        end

        // Reset in the middle of a job after two accepted pairs.
        @(negedge clk);
        start = 1'b1; len = 8'd5;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_a = 4'd1; in_b = 4'd1;
        @(negedge clk);
        in_a = 4'd2; in_b = 4'd2;
        @(negedge clk);
        in_a = 4'd5; in_b = 4'd5;
        #2 rst = 1'b1;
        #1;
        chk("midrst in_ready", int'(in_ready), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst result", int'(result), 0);
        chk("midrst mac_a", int'(mac_a), 0);
        chk("midrst mac_b", int'(mac_b), 0);
        chk("midrst mac_ci", int'(mac_ci), 0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        ja[0] = 4'd3; jb[0] = 4'd3; ja[1] = 4'd2; jb[1] = 4'd2;
        run_job("after reset", 2, 0, 0, 13);

        for (int r = 0; r < 20; r++) begin
            int n, sum;
            n = $urandom_range(0, 20);
            sum = 0;
            for (int j = 0; j < n; j++) begin
                ja[j] = 4'($urandom_range(0, 15));
                jb[j] = 4'($urandom_range(0, 15));
                sum = sum + int'(ja[j]) * int'(jb[j]);
            end
            run_job($sformatf("rand%0d", r), n, 2, 0, sum % 256);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
